// File: rtl/pte_pkg.sv
// Shared PTE definitions: walker/responder FSM states, PTE bit indices and the
// accessed/dirty update helper used by both the walker and the memory responder.
package pte_pkg;

    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;
    localparam int unsigned PTE_U = 4;
    localparam int unsigned PTE_A = 6;
    localparam int unsigned PTE_D = 7;

    typedef enum logic [2:0] {
        PTE_S_IDLE       = 3'd0,
        PTE_S_RD_REQ     = 3'd1,
        PTE_S_RD_WAIT    = 3'd2,
        PTE_S_MK_RD_REQ  = 3'd3,
        PTE_S_MK_RD_WAIT = 3'd4,
        PTE_S_MK_WR_REQ  = 3'd5,
        PTE_S_MK_WR_WAIT = 3'd6
    } pte_state_t;

    // Dirty implies accessed; with neither flag the mask is empty.
    function automatic logic [63:0] pte_ad_mask(input logic        accessed,
                                                input logic        dirty,
                                                input int unsigned a_bit = PTE_A,
                                                input int unsigned d_bit = PTE_D);
        logic [63:0] m;
        m = '0;
        if (dirty) begin
            m = (64'd1 << d_bit) | (64'd1 << a_bit);
        end else if (accessed) begin
            m = 64'd1 << a_bit;
        end
        return m;
    endfunction

    function automatic logic [63:0] pte_set_ad(input logic [63:0]  pte,
                                               input logic         accessed,
                                               input logic         dirty,
                                               input int unsigned  a_bit = PTE_A,
                                               input int unsigned  d_bit = PTE_D);
        return pte | pte_ad_mask(accessed, dirty, a_bit, d_bit);
    endfunction

endpackage

// File: rtl/pte_mem_responder_if.sv
// Memory bus port shared by the PTE responder (master) and the memory system (slave).
interface pte_mem_responder_if #(
    parameter int unsigned PA_WIDTH = 32
);
    logic                bus_req_valid;
    logic                bus_req_ready;
    logic                bus_req_we;
    logic [PA_WIDTH-1:0] bus_req_addr;
    logic [63:0]         bus_req_wdata;
    logic                bus_rsp_valid;
    logic [63:0]         bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/pte_mem_responder.sv
// PTE memory responder: serves walker PTE loads/stores and A/D read-modify-write marks
// over one bus master port. Define PTE_MARK_SKIP_EN to skip write-backs that change nothing.
module pte_mem_responder
    import pte_pkg::*;
#(
    parameter int unsigned PA_WIDTH = 32,
    parameter int unsigned A_BIT    = PTE_A,
    parameter int unsigned D_BIT    = PTE_D
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req_valid,
    input  logic [PA_WIDTH-1:0] mem_req_addr,
    input  logic [63:0]         mem_req_data,
    input  logic                mem_req_store,
    output logic                mem_rsp_valid,
    output logic [63:0]         mem_rsp_data,
    input  logic                mem_mark_valid,
    input  logic                mem_mark_accessed,
    input  logic                mem_mark_dirty,
    input  logic [63:0]         mem_mark_addr,
    output logic                mem_mark_rsp_valid,
    pte_mem_responder_if.master bus,
    output logic                busy,
    output logic                proto_err
);

    localparam logic [2:0] S_IDLE       = PTE_S_IDLE;
    localparam logic [2:0] S_RD_REQ     = PTE_S_RD_REQ;
    localparam logic [2:0] S_RD_WAIT    = PTE_S_RD_WAIT;
    localparam logic [2:0] S_MK_RD_REQ  = PTE_S_MK_RD_REQ;
    localparam logic [2:0] S_MK_RD_WAIT = PTE_S_MK_RD_WAIT;
    localparam logic [2:0] S_MK_WR_REQ  = PTE_S_MK_WR_REQ;
    localparam logic [2:0] S_MK_WR_WAIT = PTE_S_MK_WR_WAIT;

    logic [2:0]          state_q, state_d;
    logic                pend_rd_q, pend_rd_d;
    logic                pend_mk_q, pend_mk_d;
    logic [PA_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [63:0]         rd_data_q, rd_data_d;
    logic                rd_store_q, rd_store_d;
    logic [PA_WIDTH-1:0] mk_addr_q, mk_addr_d;
    logic                mk_acc_q, mk_acc_d;
    logic                mk_dirty_q, mk_dirty_d;

    logic                bus_req_valid_q, bus_req_valid_d;
    logic                bus_req_we_q, bus_req_we_d;
    logic [PA_WIDTH-1:0] bus_req_addr_q, bus_req_addr_d;
    logic [63:0]         bus_req_wdata_q, bus_req_wdata_d;
    logic                mem_rsp_valid_q, mem_rsp_valid_d;
    logic [63:0]         mem_rsp_data_q, mem_rsp_data_d;
    logic                mark_rsp_valid_q, mark_rsp_valid_d;
    logic                busy_q, busy_d;
    logic                proto_err_q, proto_err_d;

    // Request seen this cycle: either already pending or arriving right now.
    logic                rd_avail_c, mk_avail_c;
    logic [PA_WIDTH-1:0] rd_addr_c, mk_addr_c;
    logic [63:0]         rd_data_c;
    logic                rd_store_c;
    logic [63:0]         mk_new_c;
    logic                unused_bits;

    assign unused_bits = ^{mem_req_addr[2:0], mem_mark_addr[63:PA_WIDTH], mem_mark_addr[2:0]};

    // Pending flags stay set until the matching response pulses, so a second
    // pulse during service is flagged as a protocol error and dropped.
    always_comb begin
        pend_rd_d   = pend_rd_q | mem_req_valid;
        pend_mk_d   = pend_mk_q | mem_mark_valid;
        proto_err_d = proto_err_q | (mem_req_valid & pend_rd_q) | (mem_mark_valid & pend_mk_q);
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        rd_store_d  = rd_store_q;
        mk_addr_d   = mk_addr_q;
        mk_acc_d    = mk_acc_q;
        mk_dirty_d  = mk_dirty_q;

        rd_addr_c  = pend_rd_q ? rd_addr_q  : {mem_req_addr[PA_WIDTH-1:3], 3'b000};
        rd_data_c  = pend_rd_q ? rd_data_q  : mem_req_data;
        rd_store_c = pend_rd_q ? rd_store_q : mem_req_store;
        mk_addr_c  = pend_mk_q ? mk_addr_q  : {mem_mark_addr[PA_WIDTH-1:3], 3'b000};
        rd_avail_c = pend_rd_q | mem_req_valid;
        mk_avail_c = pend_mk_q | mem_mark_valid;

        if (mem_req_valid && !pend_rd_q) begin
            rd_addr_d  = rd_addr_c;
            rd_data_d  = rd_data_c;
            rd_store_d = rd_store_c;
        end
        if (mem_mark_valid && !pend_mk_q) begin
            mk_addr_d  = mk_addr_c;
            mk_acc_d   = mem_mark_accessed;
            mk_dirty_d = mem_mark_dirty;
        end

        state_d          = state_q;
        bus_req_valid_d  = bus_req_valid_q;
        bus_req_we_d     = bus_req_we_q;
        bus_req_addr_d   = bus_req_addr_q;
        bus_req_wdata_d  = bus_req_wdata_q;
        mem_rsp_valid_d  = 1'b0;
        mem_rsp_data_d   = mem_rsp_data_q;
        mark_rsp_valid_d = 1'b0;
        mk_new_c         = pte_set_ad(bus.bus_rsp_rdata, mk_acc_q, mk_dirty_q, A_BIT, D_BIT);

        case (state_q)
            S_IDLE: begin
                if (rd_avail_c) begin
                    state_d         = S_RD_REQ;
                    bus_req_valid_d = 1'b1;
                    bus_req_we_d    = rd_store_c;
                    bus_req_addr_d  = rd_addr_c;
                    bus_req_wdata_d = rd_data_c;
                end else if (mk_avail_c) begin
                    state_d         = S_MK_RD_REQ;
                    bus_req_valid_d = 1'b1;
                    bus_req_we_d    = 1'b0;
                    bus_req_addr_d  = mk_addr_c;
                    bus_req_wdata_d = '0;
                end
            end
            S_RD_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d         = S_RD_WAIT;
                    bus_req_valid_d = 1'b0;
                end
            end
            S_RD_WAIT: begin
                if (bus.bus_rsp_valid) begin
                    state_d         = S_IDLE;
                    mem_rsp_valid_d = 1'b1;
                    mem_rsp_data_d  = rd_store_q ? 64'd0 : bus.bus_rsp_rdata;
                    pend_rd_d       = 1'b0;
                end
            end
            S_MK_RD_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d         = S_MK_RD_WAIT;
                    bus_req_valid_d = 1'b0;
                end
            end
            S_MK_RD_WAIT: begin
                if (bus.bus_rsp_valid) begin
`ifdef PTE_MARK_SKIP_EN
                    if (mk_new_c == bus.bus_rsp_rdata) begin
                        state_d          = S_IDLE;
                        mark_rsp_valid_d = 1'b1;
                        pend_mk_d        = 1'b0;
                    end else begin
                        state_d         = S_MK_WR_REQ;
                        bus_req_valid_d = 1'b1;
                        bus_req_we_d    = 1'b1;
                        bus_req_wdata_d = mk_new_c;
                    end
`else
                    state_d         = S_MK_WR_REQ;
                    bus_req_valid_d = 1'b1;
                    bus_req_we_d    = 1'b1;
                    bus_req_wdata_d = mk_new_c;
`endif
                end
            end
            S_MK_WR_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d         = S_MK_WR_WAIT;
                    bus_req_valid_d = 1'b0;
                end
            end
            S_MK_WR_WAIT: begin
                if (bus.bus_rsp_valid) begin
                    state_d          = S_IDLE;
                    mark_rsp_valid_d = 1'b1;
                    pend_mk_d        = 1'b0;
                end
            end
            default: begin
                state_d         = S_IDLE;
                bus_req_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) | pend_rd_d | pend_mk_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            pend_rd_q        <= 1'b0;
            pend_mk_q        <= 1'b0;
            rd_addr_q        <= '0;
            rd_data_q        <= '0;
            rd_store_q       <= 1'b0;
            mk_addr_q        <= '0;
            mk_acc_q         <= 1'b0;
            mk_dirty_q       <= 1'b0;
            bus_req_valid_q  <= 1'b0;
            bus_req_we_q     <= 1'b0;
            bus_req_addr_q   <= '0;
            bus_req_wdata_q  <= '0;
            mem_rsp_valid_q  <= 1'b0;
            mem_rsp_data_q   <= '0;
            mark_rsp_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            proto_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pend_rd_q        <= pend_rd_d;
            pend_mk_q        <= pend_mk_d;
            rd_addr_q        <= rd_addr_d;
            rd_data_q        <= rd_data_d;
            rd_store_q       <= rd_store_d;
            mk_addr_q        <= mk_addr_d;
            mk_acc_q         <= mk_acc_d;
            mk_dirty_q       <= mk_dirty_d;
            bus_req_valid_q  <= bus_req_valid_d;
            bus_req_we_q     <= bus_req_we_d;
            bus_req_addr_q   <= bus_req_addr_d;
            bus_req_wdata_q  <= bus_req_wdata_d;
            mem_rsp_valid_q  <= mem_rsp_valid_d;
            mem_rsp_data_q   <= mem_rsp_data_d;
            mark_rsp_valid_q <= mark_rsp_valid_d;
            busy_q           <= busy_d;
            proto_err_q      <= proto_err_d;
        end
    end

    assign bus.bus_req_valid   = bus_req_valid_q;
    assign bus.bus_req_we      = bus_req_we_q;
    assign bus.bus_req_addr    = bus_req_addr_q;
    assign bus.bus_req_wdata   = bus_req_wdata_q;
    assign mem_rsp_valid       = mem_rsp_valid_q;
    assign mem_rsp_data        = mem_rsp_data_q;
    assign mem_mark_rsp_valid  = mark_rsp_valid_q;
    assign busy                = busy_q;
    assign proto_err           = proto_err_q;

endmodule
